instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Instruction fetch stage that drives the IF/ID pipeline register: maintains the program counter, issues word requests to instruction memory over a valid/ready request channel, and presents `{pc_out, instruction_out, instr_valid}` to the IF/ID register. It sits between instruction memory and IF/ID. It honours back-pressure (`stall`) from decode with a one-entry hold buffer, and honours branch/jump redirects from later stages, discarding wrong-path fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, value driven on instruction_out while no valid instruction is presented (addi x0,x0,0)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; asynchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  fetch address (word aligned)
- imem_rsp_valid  in  1  response data valid (one response per accepted request, in order)
- imem_rsp_data  in  32  fetched instruction word
- stall  in  1  decode cannot accept; output registers hold
- redirect_valid  in  1  control-flow redirect
- redirect_pc  in  32  redirect target
- pc_out  out  32  PC of presented instruction
- instruction_out  out  32  presented instruction
- instr_valid  out  1  pc_out/instruction_out are valid
- fetch_misaligned  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State machine states: REQ, WAIT, FULL, DRAIN, HALT. Reset state is REQ.
- REQ: imem_req_valid=1, imem_addr=pc. If req_valid && req_ready, go to WAIT.
- WAIT: wait for imem_rsp_valid.
  - If the output slot is free (instr_valid==0 or stall==0), load pc_out<=pc, instruction_out<=rsp_data, and instr_valid<=1. Then pc<=pc+4 and go to REQ.
  - Otherwise, capture {pc, rsp_data} into the hold buffer and go to FULL.
- FULL: no requests. When stall==0, move the hold buffer to the output, set instr_valid=1, pc<=pc+4, and go to REQ.
- Consumption: instr_valid==1 && stall==0 at an edge with no new load → instr_valid<=0 and instruction_out<=NOP_INSTR.
- Redirect has top priority at any edge:
  - pc<=redirect_pc, instr_valid<=0, instruction_out<=NOP_INSTR, hold buffer cleared.
  - Next state is DRAIN if a request is outstanding after this edge: in WAIT with no rsp this cycle, or in REQ with the handshake completing this cycle. Otherwise next state is REQ.
- DRAIN: no requests. The next imem_rsp_valid is discarded, then go to REQ. A redirect during DRAIN updates pc and stays in DRAIN.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- At most one request is outstanding at any time.

## Timing
- Reset values:
  - pc=RESET_PC, pc_out=32'h0, instruction_out=NOP_INSTR, instr_valid=0, fetch_misaligned=0, hold buffer cleared, state REQ.
  - imem_req_valid is forced 0 while rst=1.
- First request: imem_req_valid=1 in the first cycle after rst deasserts, with imem_addr=RESET_PC.
- Latency: a response arriving in cycle M with the slot free gives instr_valid=1 in cycle M+1. The next request issues in cycle M+1.
- With a zero-wait memory (ready=1, response the cycle after acceptance), throughput is one instruction per 2 cycles.
- Output registers are stable while instr_valid=1 and stall=1.
- Redirect during stall: the stall is overridden and the output is invalidated at that edge.
- Response arriving in the same cycle as a redirect: discarded, next state REQ.
- Reset mid-operation aborts immediately to reset values. Any in-flight memory response after reset is the memory's responsibility to squash.

## Configuration
- IFU_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]!=2'b00 sets fetch_misaligned=1, which is sticky until rst.
  - The FSM enters HALT: no requests, instr_valid=0, further redirects ignored.
  - A response already in flight is absorbed in HALT and discarded.
- IFU_MISALIGN_TRAP_EN undefined: redirect_pc[1:0] is forced to 2'b00, fetch_misaligned is tied 0, and the HALT state is absent.

## Test plan
- Reset release, memory ready=1 with 1-cycle response returning 32'h1111_1111, 32'h2222_2222, 32'h3333_3333 → pc_out 0x0, 0x4, 0x8 with matching instructions, each instr_valid pulse 1 cycle, 2-cycle spacing.
- stall=1 for 5 cycles while 0x4 is presented and 0x8's response returns → output holds 0x4/32'h2222_2222, state FULL, no request issued. After stall drops, 0x8 presents next cycle with no instruction lost or duplicated.
- redirect_valid with redirect_pc=32'h0000_0100 while a response is outstanding → instr_valid=0, the stale response is discarded (DRAIN), and the next imem_addr=0x100.
- RESET_PC=32'hFFFF_FFFC → presents 0xFFFF_FFFC then 0x0000_0000.
- rst asserted asynchronously mid-WAIT for 10 ns → all outputs at reset values immediately, and the first request after release is to RESET_PC.
- With IFU_MISALIGN_TRAP_EN: redirect_pc=32'h0000_0102 → fetch_misaligned=1, no further imem_req_valid until rst. Without the macro: the next fetch address is 0x100.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC, imem valid/ready requests, one-entry stall hold buffer, redirects.
// Define IFU_MISALIGN_TRAP_EN to trap (HALT) on misaligned redirect targets.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc_out,
   output logic [31:0] instruction_out,
   output logic        instr_valid,
   output logic        fetch_misaligned
);

   localparam logic [2:0] REQ   = 3'd0;
   localparam logic [2:0] WAIT  = 3'd1;
   localparam logic [2:0] FULL  = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
`ifdef IFU_MISALIGN_TRAP_EN
   localparam logic [2:0] HALT  = 3'd4;
`endif

   logic [2:0]  state, state_d;
   logic [31:0] pc, pc_d;
   logic [31:0] pc_out_d, instr_out_d;
   logic        valid_d;
   logic [31:0] hold_pc, hold_pc_d;
   logic [31:0] hold_instr, hold_instr_d;
   logic [31:0] redir_target;
   logic        redirect_live;
   logic        slot_free;

`ifdef IFU_MISALIGN_TRAP_EN
   logic misaligned_q, misaligned_d;
   logic redir_bad;

   assign redir_target     = redirect_pc;
   assign redir_bad        = redirect_pc[1:0] != 2'b00;
   assign redirect_live    = redirect_valid && (state != HALT);
   assign fetch_misaligned = misaligned_q;
`else
   logic unused_redirect_lsb;

   assign redir_target        = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsb = ^redirect_pc[1:0];
   assign redirect_live       = redirect_valid;
   assign fetch_misaligned    = 1'b0;
`endif

   assign imem_req_valid = (state == REQ) && !rst;
   assign imem_addr      = pc;
   assign slot_free      = !instr_valid || !stall;

   always_comb begin
      state_d      = state;
      pc_d         = pc;
      pc_out_d     = pc_out;
      instr_out_d  = instruction_out;
      valid_d      = instr_valid;
      hold_pc_d    = hold_pc;
      hold_instr_d = hold_instr;
`ifdef IFU_MISALIGN_TRAP_EN
      misaligned_d = misaligned_q;
`endif

      // Decode took the presented instruction; a load below overrides this.
      if (instr_valid && !stall) begin
         valid_d     = 1'b0;
         instr_out_d = NOP_INSTR;
      end

      case (state)
         REQ: begin
            if (imem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (slot_free) begin
                  pc_out_d    = pc;
                  instr_out_d = imem_rsp_data;
                  valid_d     = 1'b1;
                  pc_d        = pc + 32'd4;
                  state_d     = REQ;
               end else begin
                  hold_pc_d    = pc;
                  hold_instr_d = imem_rsp_data;
                  state_d      = FULL;
               end
            end
         end
         FULL: begin
            if (!stall) begin
               pc_out_d    = hold_pc;
               instr_out_d = hold_instr;
               valid_d     = 1'b1;
               pc_d        = pc + 32'd4;
               state_d     = REQ;
            end
         end
         DRAIN: begin
            if (imem_rsp_valid) state_d = REQ;
         end
`ifdef IFU_MISALIGN_TRAP_EN
         HALT: begin
            valid_d     = 1'b0;
            instr_out_d = NOP_INSTR;
         end
`endif
         default: state_d = REQ;
      endcase

      // Redirect wins; DRAIN only if a request is still owed a response after this edge.
      if (redirect_live) begin
         pc_d         = redir_target;
         valid_d      = 1'b0;
         instr_out_d  = NOP_INSTR;
         hold_pc_d    = 32'h0;
         hold_instr_d = 32'h0;
         if (state == DRAIN) begin
            state_d = imem_rsp_valid ? REQ : DRAIN;
         end else if ((state == WAIT && !imem_rsp_valid) || (state == REQ && imem_req_ready)) begin
            state_d = DRAIN;
         end else begin
            state_d = REQ;
         end
`ifdef IFU_MISALIGN_TRAP_EN
         if (redir_bad) begin
            misaligned_d = 1'b1;
            state_d      = HALT;
         end
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= REQ;
         pc              <= RESET_PC;
         pc_out          <= 32'h0;
         instruction_out <= NOP_INSTR;
         instr_valid     <= 1'b0;
         hold_pc         <= 32'h0;
         hold_instr      <= 32'h0;
      end else begin
         state           <= state_d;
         pc              <= pc_d;
         pc_out          <= pc_out_d;
         instruction_out <= instr_out_d;
         instr_valid     <= valid_d;
         hold_pc         <= hold_pc_d;
         hold_instr      <= hold_instr_d;
      end
   end

`ifdef IFU_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) misaligned_q <= 1'b0;
      else     misaligned_q <= misaligned_d;
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed stimulus pushes expected {pc, instr},
// monitors pop on each consumed presentation; a second instance checks PC wrap from RESET_PC.
module tb_instruction_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, rst2;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_addr, imem_rsp_data;
   logic        stall, redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] pc_out, instruction_out;
   logic        instr_valid, fetch_misaligned;

   logic        req_valid2, rsp_valid2, valid2, mis2;
   logic        ready2 = 1'b1;
   logic        stall2 = 1'b0;
   logic        redir2 = 1'b0;
   logic [31:0] redir_pc2 = 32'h0;
   logic [31:0] addr2, rsp_data2, pc_out2, instr2;

   exp_t exp_q[$];
   exp_t exp_q2[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   rsp_delay = 1;

   always #5 clk = ~clk;

   instruction_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .NOP_INSTR(32'h0000_0013)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .pc_out          (pc_out),
      .instruction_out (instruction_out),
      .instr_valid     (instr_valid),
      .fetch_misaligned(fetch_misaligned)
   );

   instruction_fetch_unit #(
      .RESET_PC (32'hFFFF_FFFC),
      .NOP_INSTR(32'h0000_0013)
   ) dut_wrap (
      .clk             (clk),
      .rst             (rst2),
      .imem_req_valid  (req_valid2),
      .imem_req_ready  (ready2),
      .imem_addr       (addr2),
      .imem_rsp_valid  (rsp_valid2),
      .imem_rsp_data   (rsp_data2),
      .stall           (stall2),
      .redirect_valid  (redir2),
      .redirect_pc     (redir_pc2),
      .pc_out          (pc_out2),
      .instruction_out (instr2),
      .instr_valid     (valid2),
      .fetch_misaligned(mis2)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h1111_1111;
         32'h0000_0004: return 32'h2222_2222;
         32'h0000_0008: return 32'h3333_3333;
         default:       return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Memory model for dut: accept at an edge, respond rsp_delay cycles later.
   initial begin : mem_model
      logic        acc, pend;
      logic [31:0] acc_addr, paddr;
      int          cnt;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      pend = 1'b0;
      paddr = 32'h0;
      cnt = 0;
      forever begin
         @(negedge clk);
         acc      = imem_req_valid && imem_req_ready && !rst;
         acc_addr = imem_addr;
         @(posedge clk);
         #1;
         if (acc) begin
            pend  = 1'b1;
            paddr = acc_addr;
            cnt   = rsp_delay;
         end
         if (rst) pend = 1'b0;
         imem_rsp_valid = 1'b0;
         if (pend) begin
            if (cnt <= 1) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = mem_word(paddr);
               pend = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   initial begin : mem_model2
      logic        acc;
      logic [31:0] acc_addr;
      rsp_valid2 = 1'b0;
      rsp_data2  = 32'h0;
      forever begin
         @(negedge clk);
         acc      = req_valid2 && !rst2;
         acc_addr = addr2;
         @(posedge clk);
         #1;
         rsp_valid2 = acc && !rst2;
         rsp_data2  = mem_word(acc_addr);
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && instr_valid && !stall && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL sb_unexpected: got pc %h instr %h, expected nothing", pc_out,
                        instruction_out);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", pc_out, e.pc);
               check("sb_instr", instruction_out, e.instr);
            end
         end
      end
   end

   initial begin : monitor2
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst2 && valid2) begin
            if (exp_q2.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL sb2_unexpected: got pc %h, expected nothing", pc_out2);
            end else begin
               e = exp_q2.pop_front();
               check("sb2_pc", pc_out2, e.pc);
               check("sb2_instr", instr2, e.instr);
            end
         end
      end
   end

   initial begin : stimulus
      rst = 1'b1;
      rst2 = 1'b1;
      imem_req_ready = 1'b1;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      tick(3);
      check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_instr_out", instruction_out, 32'h0000_0013);
      check("rst_pc_out", pc_out, 32'h0);
      check("rst_misaligned", {31'h0, fetch_misaligned}, 32'h0);

      exp_q.push_back('{pc: 32'h0, instr: 32'h1111_1111});
      exp_q.push_back('{pc: 32'h4, instr: 32'h2222_2222});
      exp_q.push_back('{pc: 32'h8, instr: 32'h3333_3333});
      exp_q2.push_back('{pc: 32'hFFFF_FFFC, instr: 32'hA5A5_FFFC});
      exp_q2.push_back('{pc: 32'h0, instr: 32'h1111_1111});
      rst = 1'b0;
      rst2 = 1'b0;
      #1;
      check("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("first_req_addr", imem_addr, 32'h0);
      check("wrap_first_addr", addr2, 32'hFFFF_FFFC);
      tick(2);
      check("wrap_second_addr", addr2, 32'h0);
      tick(1);
      check("pulse_low_c3", {31'h0, instr_valid}, 32'h0);
      tick(1);
      stall = 1'b1;
      check("present_4_pc", pc_out, 32'h4);
      tick(1);
      rst2 = 1'b1;
      tick(1);
      check("full_no_req_c6", {31'h0, imem_req_valid}, 32'h0);
      check("hold_pc_c6", pc_out, 32'h4);
      check("hold_instr_c6", instruction_out, 32'h2222_2222);
      check("hold_valid_c6", {31'h0, instr_valid}, 32'h1);
      tick(2);
      check("full_no_req_c8", {31'h0, imem_req_valid}, 32'h0);
      check("hold_pc_c8", pc_out, 32'h4);
      tick(1);
      stall = 1'b0;
      tick(1);
      check("after_stall_pc", pc_out, 32'h8);
      check("next_req_addr", imem_addr, 32'hC);
      rsp_delay = 3;
      tick(1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0100;
      exp_q.push_back('{pc: 32'h100, instr: 32'h5A5A_0100});
      tick(1);
      redirect_valid = 1'b0;
      rsp_delay = 1;
      check("drain_valid", {31'h0, instr_valid}, 32'h0);
      check("drain_no_req", {31'h0, imem_req_valid}, 32'h0);
      tick(1);
      check("drain_no_req2", {31'h0, imem_req_valid}, 32'h0);
      tick(1);
      check("redir_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("redir_req_addr", imem_addr, 32'h100);
      tick(2);
      rsp_delay = 4;
      tick(1);
      #3;
      rst = 1'b1;
      #1;
      check("async_req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("async_instr_valid", {31'h0, instr_valid}, 32'h0);
      check("async_instr_out", instruction_out, 32'h0000_0013);
      check("async_pc_out", pc_out, 32'h0);
      #10;
      tick(1);
      rst = 1'b0;
      rsp_delay = 1;
      exp_q.push_back('{pc: 32'h0, instr: 32'h1111_1111});
      #1;
      check("rerst_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("rerst_req_addr", imem_addr, 32'h0);
      tick(3);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0102;
`ifndef IFU_MISALIGN_TRAP_EN
      exp_q.push_back('{pc: 32'h100, instr: 32'h5A5A_0100});
`endif
      tick(1);
      redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      check("trap_no_req", {31'h0, imem_req_valid}, 32'h0);
      check("trap_flag", {31'h0, fetch_misaligned}, 32'h1);
      check("trap_valid", {31'h0, instr_valid}, 32'h0);
      tick(1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      tick(1);
      redirect_valid = 1'b0;
      tick(3);
      check("trap_no_req_late", {31'h0, imem_req_valid}, 32'h0);
      check("trap_flag_sticky", {31'h0, fetch_misaligned}, 32'h1);
`else
      check("misalign_req_valid", {31'h0, imem_req_valid}, 32'h1);
      check("misalign_req_addr", imem_addr, 32'h100);
      check("misalign_flag", {31'h0, fetch_misaligned}, 32'h0);
      tick(3);
`endif
      check("sb_remaining", exp_q.size(), 32'h0);
      check("sb2_remaining", exp_q2.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
